// File: rtl/thread_state_mem.sv
// Per-thread state array feeding the scheduler: two combinational read ports, two merged write paths.
// Optional illegal-transition checker enabled by defining THREAD_STATE_CHECK_EN.

`ifndef MSB
`define MSB(x) ($clog2((x) + 1) - 1)
`endif
`ifndef THREAD_STATE_MSB
`define THREAD_STATE_MSB 3
`endif
`ifndef THREAD_STATE_NONE
`define THREAD_STATE_NONE 4'h0
`endif
`ifndef THREAD_STATE_READY
`define THREAD_STATE_READY 4'h1
`endif
`ifndef THREAD_STATE_BUSY
`define THREAD_STATE_BUSY 4'h2
`endif
`ifndef THREAD_STATE_WR_RDY
`define THREAD_STATE_WR_RDY 4'h3
`endif

module thread_state_mem #(
    parameter int N_CORES       = 4,
    parameter int N_THREADS     = 12,
    parameter int N_THREADS_MSB = `MSB(N_THREADS - 1)
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [N_THREADS_MSB:0]     ts_rd_num,
    output logic [`THREAD_STATE_MSB:0] ts_rd,
    input  logic [N_THREADS_MSB:0]     ts_rd2_num,
    output logic [`THREAD_STATE_MSB:0] ts_rd2,
    input  logic                       wr_a_en,
    input  logic [N_THREADS_MSB:0]     wr_a_num,
    input  logic [`THREAD_STATE_MSB:0] wr_a_state,
    input  logic                       wr_b_valid,
    output logic                       wr_b_ready,
    input  logic [N_THREADS_MSB:0]     wr_b_num,
    input  logic [`THREAD_STATE_MSB:0] wr_b_state,
    output logic                       any_wr_rdy,
    output logic                       err
);

    localparam int NW = N_THREADS_MSB + 1;
    localparam int SW = `THREAD_STATE_MSB + 1;
    localparam logic [NW:0] N_LIMIT = (NW + 1)'(N_THREADS);

    if (N_CORES < 1 || N_THREADS < 2 || N_THREADS > 64) begin : g_param_check
        $error("thread_state_mem: N_CORES must be >= 1 and N_THREADS in 2..64");
    end

    function automatic logic in_range(input logic [NW-1:0] num);
        return {1'b0, num} < N_LIMIT;
    endfunction

    logic [SW-1:0] mem [N_THREADS];

    logic          a1_valid;
    logic [NW-1:0] a1_num;
    logic [SW-1:0] a1_state;

    logic          b1_valid;
    logic [NW-1:0] b1_num;
    logic [SW-1:0] b1_state;

    logic          skid_valid;
    logic [NW-1:0] skid_num;
    logic [SW-1:0] skid_state;

    logic          any_wr_rdy_q;
    logic          b_commit;
    logic          b1_free;
    logic          b_fire;
    logic          b_take;
    logic          mem_has_wr_rdy;

    // Port B handshake: a request transfers on any rising CLK edge where
    // wr_b_valid & wr_b_ready are both high; wr_b_ready depends only on
    // registered skid occupancy (and reset), never on wr_b_valid.
    assign wr_b_ready = RESET_N & ~skid_valid;
    assign b_fire     = wr_b_valid & wr_b_ready;
    assign b_take     = b_fire & in_range(wr_b_num);

    // A same-thread A1 wins the cycle; B1 retries next cycle so B ends up last.
    assign b_commit = b1_valid & ~(a1_valid & (a1_num == b1_num));
    assign b1_free  = ~b1_valid | b_commit;

    assign ts_rd  = in_range(ts_rd_num)  ? mem[ts_rd_num]  : `THREAD_STATE_NONE;
    assign ts_rd2 = in_range(ts_rd2_num) ? mem[ts_rd2_num] : `THREAD_STATE_NONE;

    always_comb begin
        mem_has_wr_rdy = 1'b0;
        for (int i = 0; i < N_THREADS; i++) begin
            if (mem[i] == `THREAD_STATE_WR_RDY) mem_has_wr_rdy = 1'b1;
        end
    end

    assign any_wr_rdy = any_wr_rdy_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            a1_valid <= 1'b0;
            a1_num   <= '0;
            a1_state <= '0;
        end else begin
            a1_valid <= wr_a_en & in_range(wr_a_num);
            a1_num   <= wr_a_num;
            a1_state <= wr_a_state;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            b1_valid   <= 1'b0;
            b1_num     <= '0;
            b1_state   <= '0;
            skid_valid <= 1'b0;
            skid_num   <= '0;
            skid_state <= '0;
        end else if (b1_free) begin
            // Skid entry is older than anything arriving now, so it refills B1 first.
            if (skid_valid) begin
                b1_valid   <= 1'b1;
                b1_num     <= skid_num;
                b1_state   <= skid_state;
                skid_valid <= 1'b0;
            end else if (b_take) begin
                b1_valid <= 1'b1;
                b1_num   <= wr_b_num;
                b1_state <= wr_b_state;
            end else begin
                b1_valid <= 1'b0;
            end
        end else if (b_take) begin
            skid_valid <= 1'b1;
            skid_num   <= wr_b_num;
            skid_state <= wr_b_state;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < N_THREADS; i++) mem[i] <= `THREAD_STATE_NONE;
        end else begin
            for (int i = 0; i < N_THREADS; i++) begin
                if (b_commit && b1_num == NW'(i)) begin
                    mem[i] <= b1_state;
                end else if (a1_valid && a1_num == NW'(i)) begin
                    mem[i] <= a1_state;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) any_wr_rdy_q <= 1'b0;
        else          any_wr_rdy_q <= mem_has_wr_rdy;
    end

`ifdef THREAD_STATE_CHECK_EN
    logic err_q;
    logic err_event;

    // b1_num is always in range once captured, so the array lookup is safe.
    assign err_event = (b_commit && mem[b1_num] == `THREAD_STATE_WR_RDY)
                     | (wr_a_en & ~in_range(wr_a_num))
                     | (b_fire & ~in_range(wr_b_num));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) err_q <= 1'b0;
        else          err_q <= err_q | err_event;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
